// File: rtl/latch_seq_pkg.sv
// Shared types and helpers for the latch sequencer / self-checker.
package latch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT_CLR,
        RELEASE,
        APPLY,
        CHECK,
        DONE
    } state_t;

    typedef struct packed {
        logic known;
        logic val;
    } gold_t;

    // Galois right-shift mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? LFSR_TAPS : 8'h00);
    endfunction

    // Returns {a,b} for the given pattern source
    function automatic logic [1:0] pattern(input logic m, input logic [1:0] step_lo,
                                           input logic [1:0] lfsr_lo);
        return m ? lfsr_lo : step_lo;
    endfunction

endpackage

// File: rtl/latch_golden_model.sv
// Next-golden and mismatch logic for the SR, JK and D NOR latches.
module latch_golden_model
    import latch_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] sr_gold,
    input  logic [1:0] jk_gold,
    input  logic [1:0] d_gold,
    input  logic       sr_q,
    input  logic       sr_qn,
    input  logic       jk_q,
    input  logic       jk_qn,
    input  logic       d_q,
    input  logic       d_qn,
    output logic [1:0] sr_next,
    output logic [1:0] jk_next,
    output logic [1:0] d_next,
    output logic       mismatch
);

    gold_t sr_n, jk_n, d_n;

    always_comb begin
        sr_n = gold_t'(sr_gold);
        jk_n = gold_t'(jk_gold);
        d_n  = gold_t'(d_gold);
        // 11 makes SR ambiguous and JK oscillate, so both become unknown
        case ({a, b})
            2'b10: begin sr_n = gold_t'(2'b11); jk_n = gold_t'(2'b11); end
            2'b01: begin sr_n = gold_t'(2'b10); jk_n = gold_t'(2'b10); end
            2'b11: begin sr_n.known = 1'b0;     jk_n.known = 1'b0;     end
            default: ;
        endcase
        if (b) begin
            d_n.known = 1'b1;
            d_n.val   = a;
        end
        mismatch = (sr_n.known && (sr_q != sr_n.val || sr_qn != ~sr_n.val)) ||
                   (jk_n.known && (jk_q != jk_n.val || jk_qn != ~jk_n.val)) ||
                   (d_n.known  && (d_q  != d_n.val  || d_qn  != ~d_n.val));
    end

    assign sr_next = sr_n;
    assign jk_next = jk_n;
    assign d_next  = d_n;

endmodule

// File: rtl/latch_seq_ctrl.sv
// Sequencer and self-checker driving the latches block through a pattern run.
//   state    | meaning
//   IDLE     | clr held, waiting for start
//   INIT_CLR | clr high for INIT_CYC cycles, golden forced to 0
//   RELEASE  | one cycle with all latch inputs low
//   APPLY    | pattern held on a/b for SETTLE_CYC cycles
//   CHECK    | sample NOR outputs, update golden, count error
//   DONE     | one-cycle done pulse, pass valid
module latch_seq_ctrl
    import latch_seq_pkg::*;
#(
    parameter int         NUM_STEPS  = 8,
    parameter int         SETTLE_CYC = 2,
    parameter int         INIT_CYC   = 2,
    parameter int         ERR_W      = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             a,
    output logic             b,
    output logic             preset,
    output logic             clr,
    input  logic             sr_q,
    input  logic             sr_qn,
    input  logic             jk_q,
    input  logic             jk_qn,
    input  logic             d_q,
    input  logic             d_qn,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [15:0] INIT_LD   = 16'(INIT_CYC - 1);
    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC - 1);
    localparam logic [7:0]  LAST_STEP = 8'(NUM_STEPS);

    state_t     state;
    logic       mode_q;
    logic [7:0] step;
    logic [7:0] lfsr;
    logic [15:0] tmr;
    gold_t      sr_gold, jk_gold, d_gold;
    logic [1:0] sr_next, jk_next, d_next;
    logic       mismatch;
    logic [7:0] step_nxt;
    logic [7:0] lfsr_nxt;

    assign step_nxt = step + 8'd1;
    assign lfsr_nxt = lfsr_step(lfsr);
    assign preset   = 1'b0;

    latch_golden_model u_gold (
        .a        (a),
        .b        (b),
        .sr_gold  (sr_gold),
        .jk_gold  (jk_gold),
        .d_gold   (d_gold),
        .sr_q     (sr_q),
        .sr_qn    (sr_qn),
        .jk_q     (jk_q),
        .jk_qn    (jk_qn),
        .d_q      (d_q),
        .d_qn     (d_qn),
        .sr_next  (sr_next),
        .jk_next  (jk_next),
        .d_next   (d_next),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a       <= 1'b0;
            b       <= 1'b0;
            clr     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            lfsr    <= LFSR_SEED;
            mode_q  <= 1'b0;
            step    <= '0;
            tmr     <= '0;
            sr_gold <= '0;
            jk_gold <= '0;
            d_gold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= INIT_CLR;
                        busy    <= 1'b1;
                        mode_q  <= mode;
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        lfsr    <= LFSR_SEED;
                        step    <= '0;
                        tmr     <= INIT_LD;
                        sr_gold <= gold_t'(2'b10);
                        jk_gold <= gold_t'(2'b10);
                        d_gold  <= gold_t'(2'b10);
                    end
                end
                INIT_CLR: begin
                    if (tmr == '0) begin
                        state <= RELEASE;
                        clr   <= 1'b0;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                RELEASE: begin
                    state    <= APPLY;
                    {a, b}   <= pattern(mode_q, step[1:0], lfsr[1:0]);
                    tmr      <= SETTLE_LD;
                end
                APPLY: begin
                    if (tmr == '0) state <= CHECK;
                    else           tmr   <= tmr - 16'd1;
                end
                CHECK: begin
                    sr_gold <= gold_t'(sr_next);
                    jk_gold <= gold_t'(jk_next);
                    d_gold  <= gold_t'(d_next);
                    if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    step <= step_nxt;
                    lfsr <= lfsr_nxt;
                    if (step_nxt == LAST_STEP) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        pass   <= (err_cnt == '0) && !mismatch;
                        {a, b} <= 2'b00;
                        clr    <= 1'b1;
                    end else begin
                        state  <= APPLY;
                        {a, b} <= pattern(mode_q, step_nxt[1:0], lfsr_nxt[1:0]);
                        tmr    <= SETTLE_LD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_seq_ctrl.sv
// Bench for latch_seq_ctrl: behavioural NOR latches, randomized directed runs.
module tb_latch_seq_ctrl;

    localparam int NS      = 8;
    localparam int SC      = 2;
    localparam int IC      = 2;
    localparam int RUN_CYC = IC + 1 + NS * (SC + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;

    logic a, b, preset, clr, busy, done, pass;
    logic [7:0] err_cnt;
    logic sr_q, sr_qn, jk_q, jk_qn, d_q, d_qn;
    logic a2, b2, preset2, clr2, busy2, done2, pass2;
    logic [1:0] err2;

    logic m_sr_q = 1'b0, m_sr_qn = 1'b1;
    logic m_jk_q = 1'b0, m_jk_qn = 1'b1;
    logic m_d_q  = 1'b0, m_d_qn  = 1'b1;
    bit   jk_stuck = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [1:0] pat [NS];
    int exp_err;

    assign sr_q  = m_sr_q;
    assign sr_qn = m_sr_qn;
    assign jk_q  = jk_stuck ? 1'b0 : m_jk_q;
    assign jk_qn = m_jk_qn;
    assign d_q   = m_d_q;
    assign d_qn  = m_d_qn;

    latch_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a(a), .b(b), .preset(preset), .clr(clr),
        .sr_q(sr_q), .sr_qn(sr_qn), .jk_q(jk_q), .jk_qn(jk_qn),
        .d_q(d_q), .d_qn(d_qn),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
    );

    // Narrow counter, D outputs swapped: every check fails
    latch_seq_ctrl #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a(a2), .b(b2), .preset(preset2), .clr(clr2),
        .sr_q(m_sr_q), .sr_qn(m_sr_qn), .jk_q(m_jk_q), .jk_qn(m_jk_qn),
        .d_q(m_d_qn), .d_qn(m_d_q),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
    );

    always #5 clk = ~clk;

    // Ideal level-sensitive NOR latches
    always @(a or b or clr or preset) begin
        if (clr) begin
            m_sr_q = 1'b0; m_sr_qn = 1'b1;
            m_jk_q = 1'b0; m_jk_qn = 1'b1;
            m_d_q  = 1'b0; m_d_qn  = 1'b1;
        end else begin
            case ({a, b})
                2'b10: begin m_sr_q = 1'b1; m_sr_qn = 1'b0; m_jk_q = 1'b1; m_jk_qn = 1'b0; end
                2'b01: begin m_sr_q = 1'b0; m_sr_qn = 1'b1; m_jk_q = 1'b0; m_jk_qn = 1'b1; end
                2'b11: begin
                    m_sr_q = 1'b0; m_sr_qn = 1'b0;
                    m_jk_q = 1'($urandom_range(0, 1)); m_jk_qn = ~m_jk_q;
                end
                default: begin
                    if (m_sr_q == m_sr_qn) begin
                        m_sr_q = 1'($urandom_range(0, 1)); m_sr_qn = ~m_sr_q;
                    end
                end
            endcase
            if (b) begin
                m_d_q = a; m_d_qn = ~a;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pattern list and expected JK-stuck error count, straight from the rules
    task automatic build_ref(input bit m);
        logic [7:0] l = 8'hA5;
        bit known = 1'b1;
        bit val = 1'b0;
        exp_err = 0;
        for (int s = 0; s < NS; s++) begin
            pat[s] = m ? 2'(l % 4) : 2'(s % 4);
            l = (l >> 1) ^ ((l % 2 == 1) ? 8'hB8 : 8'h00);
            case (pat[s])
                2'b10: begin known = 1'b1; val = 1'b1; end
                2'b01: begin known = 1'b1; val = 1'b0; end
                2'b11: known = 1'b0;
                default: ;
            endcase
            if (known && val) exp_err++;
        end
    endtask

    function automatic logic [5:0] exp_wave(input int k);
        int s;
        if (k <= IC)           return 6'b101000;
        else if (k == IC + 1)  return 6'b100000;
        else if (k < RUN_CYC) begin
            s = (k - IC - 2) / (SC + 1);
            return {3'b100, pat[s], 1'b0};
        end
        return 6'b111000;
    endfunction

    task automatic run(input bit m, input bit stuck, input int restart_at);
        int e;
        jk_stuck = stuck;
        build_ref(m);
        e = stuck ? exp_err : 0;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        for (int k = 1; k <= RUN_CYC; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            mode  = 1'($urandom_range(0, 1));
            chk("wave", {busy, done, clr, a, b, preset}, exp_wave(k));
            chk("wave2", {busy2, done2, clr2, a2, b2, preset2}, exp_wave(k));
            if (k == RUN_CYC) begin
                chk("err_cnt", err_cnt, e);
                chk("pass", pass, (e == 0));
                chk("err_sat", err2, 3);
                chk("pass2", pass2, 0);
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_after", {busy, done, clr, a, b, preset}, 6'b001000);
        chk("pass_hold", pass, (e == 0));
        chk("err_hold", err_cnt, e);
    endtask

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        chk("rst_wave", {busy, done, clr, a, b, preset}, 6'b001000);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 1'b0, 0);
        run(1'b0, 1'b1, 0);
        chk("jk_stuck_walk_err", exp_err, 2);
        run(1'b0, 1'b0, 5);
        run(1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, RUN_CYC - 2)) : 0);

        // Reset during the third APPLY
        jk_stuck = 1'b0;
        build_ref(1'b0);
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        for (int k = 1; k <= IC + 2 + 2 * (SC + 1); k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_abort_wave", {busy, done, clr, a, b, preset}, exp_wave(IC + 2 + 2 * (SC + 1)));
        #2 rst = 1'b1;
        #1;
        chk("abort_wave", {busy, done, clr, a, b, preset}, 6'b001000);
        chk("abort_err", err_cnt, 0);
        #1 rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        run(1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
